// File: rtl/mem_port_arbiter.sv
// Two-master arbiter placing instruction fetch and load/store traffic on one memory port.
// Data wins ties, but fetch is granted once STARVE_LIMIT data grants have passed it by.
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                i_inst_req,
    input  logic [ADDR_W-1:0]   i_inst_addr,
    input  logic                i_inst_flush,
    output logic [DATA_W-1:0]   o_inst_rdata,
    output logic                o_inst_ready,
    input  logic                i_data_req,
    input  logic                i_data_we,
    input  logic [ADDR_W-1:0]   i_data_addr,
    input  logic [DATA_W-1:0]   i_data_wdata,
    input  logic [DATA_W/8-1:0] i_data_wmask,
    output logic [DATA_W-1:0]   o_data_rdata,
    output logic                o_data_ready,
    output logic                o_mem_req,
    output logic                o_mem_we,
    output logic [ADDR_W-1:0]   o_mem_addr,
    output logic [DATA_W-1:0]   o_mem_wdata,
    output logic [DATA_W/8-1:0] o_mem_wmask,
    input  logic [DATA_W-1:0]   i_mem_rdata,
    input  logic                i_mem_ready
);
    // state     | meaning
    // IDLE      | bus free, arbitrate eligible requesters
    // INST_BUSY | fetch read outstanding on the bus
    // DATA_BUSY | load/store outstanding on the bus
    typedef enum logic [1:0] {IDLE, INST_BUSY, DATA_BUSY} state_t;

    localparam int MASK_W = DATA_W / 8;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t              r_state;
    logic [3:0]          r_starve_cnt;
    logic                r_cancel;
    logic                r_mem_req;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic [MASK_W-1:0]   r_mem_wmask;
    logic [DATA_W-1:0]   r_inst_rdata;
    logic [DATA_W-1:0]   r_data_rdata;
    logic                r_inst_ready;
    logic                r_data_ready;

    logic w_inst_elig;
    logic w_data_elig;
    logic w_grant_inst;
    logic w_grant_data;

    // A requester's level is still high in its own completion cycle; mask it there.
    assign w_inst_elig  = i_inst_req && !r_inst_ready && !i_inst_flush;
    assign w_data_elig  = i_data_req && !r_data_ready;
    assign w_grant_inst = w_inst_elig && (!w_data_elig || r_starve_cnt == LIMIT);
    assign w_grant_data = w_data_elig && !w_grant_inst;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_starve_cnt <= '0;
            r_cancel     <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
            r_inst_rdata <= '0;
            r_data_rdata <= '0;
            r_inst_ready <= 1'b0;
            r_data_ready <= 1'b0;
        end else begin
            r_inst_ready <= 1'b0;
            r_data_ready <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_inst) begin
                        r_state     <= INST_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= i_inst_addr;
                        r_mem_wdata <= '0;
                        r_mem_wmask <= '0;
                    end else if (w_grant_data) begin
                        r_state     <= DATA_BUSY;
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= i_data_we;
                        r_mem_addr  <= i_data_addr;
                        r_mem_wdata <= i_data_wdata;
                        r_mem_wmask <= i_data_we ? i_data_wmask : '0;
                    end
                    if (w_grant_inst || !i_inst_req)
                        r_starve_cnt <= '0;
                    else if (w_grant_data && r_starve_cnt != LIMIT)
                        r_starve_cnt <= r_starve_cnt + 4'd1;
                end
                INST_BUSY: begin
                    if (i_mem_ready) begin
                        r_state   <= IDLE;
                        r_mem_req <= 1'b0;
                        r_cancel  <= 1'b0;
                        // A read superseded by a jump still drains, but fetch never sees it.
                        if (!r_cancel && !i_inst_flush) begin
                            r_inst_ready <= 1'b1;
                            r_inst_rdata <= i_mem_rdata;
                        end
                    end else if (i_inst_flush) begin
                        r_cancel <= 1'b1;
                    end
                end
                DATA_BUSY: begin
                    if (i_mem_ready) begin
                        r_state      <= IDLE;
                        r_mem_req    <= 1'b0;
                        r_data_ready <= 1'b1;
                        if (!r_mem_we)
                            r_data_rdata <= i_mem_rdata;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_mem_req    = r_mem_req;
    assign o_mem_we     = r_mem_we;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_wmask  = r_mem_wmask;
    assign o_inst_rdata = r_inst_rdata;
    assign o_inst_ready = r_inst_ready;
    assign o_data_rdata = r_data_rdata;
    assign o_data_ready = r_data_ready;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fetch, contention, starvation, flush, reset and masking.
// Inputs change 1ns after each rising edge; outputs are checked at that same point.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        inst_req, inst_flush, inst_ready;
    logic [31:0] inst_addr, inst_rdata;
    logic        data_req, data_we, data_ready;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic [3:0]  data_wmask;
    logic        mem_req, mem_we, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wmask;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_inst_req   (inst_req),
        .i_inst_addr  (inst_addr),
        .i_inst_flush (inst_flush),
        .o_inst_rdata (inst_rdata),
        .o_inst_ready (inst_ready),
        .i_data_req   (data_req),
        .i_data_we    (data_we),
        .i_data_addr  (data_addr),
        .i_data_wdata (data_wdata),
        .i_data_wmask (data_wmask),
        .o_data_rdata (data_rdata),
        .o_data_ready (data_ready),
        .o_mem_req    (mem_req),
        .o_mem_we     (mem_we),
        .o_mem_addr   (mem_addr),
        .o_mem_wdata  (mem_wdata),
        .o_mem_wmask  (mem_wmask),
        .i_mem_rdata  (mem_rdata),
        .i_mem_ready  (mem_ready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s @cycle %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    // Advance one cycle; the two ready pulses must never coincide.
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        chk("ready_excl", {63'd0, inst_ready & data_ready}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        inst_req = 0; inst_addr = 0; inst_flush = 0;
        data_req = 0; data_we = 0; data_addr = 0; data_wdata = 0; data_wmask = 0;
        mem_ready = 0; mem_rdata = 0;

        // Reset state
        step();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_inst_ready", inst_ready, 0);
        chk("rst_data_rdata", data_rdata, 0);
        rst_n = 1'b1;

        // Single fetch, memory answers on the first mem_req cycle
        step();
        inst_req = 1; inst_addr = 32'h8000_0000;
        step();
        chk("f1_mem_req", mem_req, 1);
        chk("f1_mem_addr", mem_addr, 32'h8000_0000);
        chk("f1_mem_we", mem_we, 0);
        chk("f1_mem_wmask", mem_wmask, 0);
        mem_ready = 1; mem_rdata = 32'h0000_0013;
        step();
        chk("f1_inst_ready", inst_ready, 1);
        chk("f1_inst_rdata", inst_rdata, 32'h0000_0013);
        chk("f1_mem_req_drop", mem_req, 0);
        mem_ready = 0;
        // inst_req stays high through the ready cycle: no duplicate grant
        step();
        chk("stale_inst_no_req", mem_req, 0);
        chk("stale_inst_no_ready", inst_ready, 0);

        // Contention: write and fetch requested together, data first
        inst_req = 1; inst_addr = 32'h8000_0004;
        data_req = 1; data_we = 1; data_addr = 32'h0000_1000;
        data_wdata = 32'hDEAD_BEEF; data_wmask = 4'hF;
        step();
        chk("ct_mem_req", mem_req, 1);
        chk("ct_mem_we", mem_we, 1);
        chk("ct_mem_addr", mem_addr, 32'h0000_1000);
        chk("ct_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
        chk("ct_mem_wmask", mem_wmask, 4'hF);
        mem_ready = 1; mem_rdata = 32'h5555_5555;
        step();
        chk("ct_data_ready", data_ready, 1);
        chk("ct_write_no_rdata", data_rdata, 0);
        chk("ct_inst_ready", inst_ready, 0);
        mem_ready = 0;
        // data_req left high one cycle past data_ready: fetch must win, not a repeat write
        step();
        chk("ct_inst_grant", mem_req, 1);
        chk("ct_inst_addr", mem_addr, 32'h8000_0004);
        chk("ct_inst_we", mem_we, 0);
        chk("ct_inst_wmask", mem_wmask, 0);
        data_req = 0;
        mem_ready = 1; mem_rdata = 32'h0010_0093;
        step();
        chk("ct_inst_ready", inst_ready, 1);
        chk("ct_inst_rdata", inst_rdata, 32'h0010_0093);
        inst_req = 0; mem_ready = 0;
        step();
        chk("ct_idle", mem_req, 0);

        // Starvation: fetch kept ineligible in each data completion cycle via flush,
        // so both requesters contend in every following idle cycle
        inst_req = 1; inst_addr = 32'h8000_0100;
        data_req = 1; data_we = 0; data_addr = 32'h0000_2000; data_wmask = 4'hF;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("sv_data_grant", mem_req, 1);
            chk("sv_data_addr", mem_addr, 32'h0000_2000 + 32'(4 * k));
            chk("sv_read_wmask", mem_wmask, 0);
            mem_ready = 1; mem_rdata = 32'hA0 + 32'(k);
            step();
            chk("sv_data_ready", data_ready, 1);
            chk("sv_data_rdata", data_rdata, 32'hA0 + 32'(k));
            mem_ready = 0; inst_flush = 1; data_addr = 32'h0000_2004 + 32'(4 * k);
            step();
            chk("sv_gap_idle", mem_req, 0);
            inst_flush = 0;
        end
        step();
        chk("sv_inst_grant", mem_req, 1);
        chk("sv_inst_addr", mem_addr, 32'h8000_0100);
        chk("sv_inst_we", mem_we, 0);
        mem_ready = 1; mem_rdata = 32'h1357_9BDF;
        step();
        chk("sv_inst_ready", inst_ready, 1);
        chk("sv_inst_rdata", inst_rdata, 32'h1357_9BDF);
        inst_req = 0; mem_ready = 0;
        step();
        chk("sv_data_resume", mem_req, 1);
        chk("sv_data_resume_addr", mem_addr, 32'h0000_2010);
        mem_ready = 1; mem_rdata = 32'hB0;
        step();
        chk("sv_resume_ready", data_ready, 1);
        data_req = 0; mem_ready = 0;
        step();

        // Flush: slow fetch cancelled on its 2nd busy cycle
        inst_req = 1; inst_addr = 32'h8000_0020;
        step();
        chk("fl_grant_addr", mem_addr, 32'h8000_0020);
        step();
        inst_flush = 1;
        step();
        inst_flush = 0; inst_addr = 32'h8000_0040;
        chk("fl_still_busy", mem_req, 1);
        chk("fl_addr_frozen", mem_addr, 32'h8000_0020);
        step();
        step();
        step();
        mem_ready = 1; mem_rdata = 32'h0000_0BAD;
        step();
        chk("fl_no_ready", inst_ready, 0);
        chk("fl_rdata_kept", inst_rdata, 32'h1357_9BDF);
        chk("fl_req_drop", mem_req, 0);
        mem_ready = 0;
        step();
        chk("fl_new_grant", mem_req, 1);
        chk("fl_new_addr", mem_addr, 32'h8000_0040);
        mem_ready = 1; mem_rdata = 32'h0040_006F;
        step();
        chk("fl_new_ready", inst_ready, 1);
        chk("fl_new_rdata", inst_rdata, 32'h0040_006F);
        inst_req = 0; mem_ready = 0;
        step();

        // Stray mem_ready in IDLE
        mem_ready = 1;
        step();
        chk("idle_rdy_inst", inst_ready, 0);
        chk("idle_rdy_data", data_ready, 0);
        chk("idle_rdy_req", mem_req, 0);
        mem_ready = 0;

        // Reset during DATA_BUSY, mem_ready arriving just after
        data_req = 1; data_we = 1; data_addr = 32'h0000_3000;
        data_wdata = 32'h1234_5678; data_wmask = 4'h3;
        step();
        chk("rm_busy_wmask", mem_wmask, 4'h3);
        rst_n = 0;
        step();
        chk("rm_mem_req", mem_req, 0);
        chk("rm_mem_we", mem_we, 0);
        chk("rm_mem_addr", mem_addr, 0);
        chk("rm_mem_wdata", mem_wdata, 0);
        chk("rm_mem_wmask", mem_wmask, 0);
        chk("rm_inst_rdata", inst_rdata, 0);
        chk("rm_data_rdata", data_rdata, 0);
        rst_n = 1; data_req = 0; mem_ready = 1;
        step();
        chk("rm_no_data_ready", data_ready, 0);
        chk("rm_idle", mem_req, 0);
        mem_ready = 0;
        data_req = 1; data_we = 0; data_addr = 32'h0000_3004;
        step();
        chk("rm_next_grant", mem_req, 1);
        chk("rm_next_addr", mem_addr, 32'h0000_3004);
        mem_ready = 1; mem_rdata = 32'h0000_CAFE;
        step();
        chk("rm_next_ready", data_ready, 1);
        chk("rm_next_rdata", data_rdata, 32'h0000_CAFE);
        data_req = 0; mem_ready = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single memory port between instruction fetch and load/store.
- Fetch presents its read enable and current instruction address. The LSU presents read/write requests.
- The block serialises them onto one downstream bus with a 3-state FSM.
- Data has priority, with starvation protection for fetch. Fetch can flush an in-flight instruction read on a jump.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
STARVE_LIMIT, 4, consecutive data grants allowed while inst_req waits; range 1..15

Ports:
clk  in  1  core clock
rst_n  in  1  reset, synchronous, active-low
inst_req  in  1  fetch read request, level, held until inst_ready
inst_addr  in  ADDR_W  fetch address, stable while inst_req
inst_flush  in  1  1-cycle pulse, cancel outstanding fetch (jump taken)
inst_rdata  out  DATA_W  instruction word, valid with inst_ready
inst_ready  out  1  1-cycle completion pulse to fetch
data_req  in  1  LSU request, level, held until data_ready
data_we  in  1  1 = write
data_addr  in  ADDR_W  LSU address
data_wdata  in  DATA_W  store data
data_wmask  in  DATA_W/8  byte enables for writes
data_rdata  out  DATA_W  load data, valid with data_ready
data_ready  out  1  1-cycle completion pulse to LSU
mem_req  out  1  downstream request, held until mem_ready
mem_we  out  1  downstream write
mem_addr  out  ADDR_W  downstream address
mem_wdata  out  DATA_W  downstream store data
mem_wmask  out  DATA_W/8  downstream byte enables; 0 on reads
mem_rdata  in  DATA_W  downstream read data
mem_ready  in  1  downstream completion, 1 cycle; may coincide with first mem_req cycle

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE.
  - mem_req, mem_we, mem_wmask, inst_ready, data_ready = 0.
  - mem_addr, mem_wdata, inst_rdata, data_rdata = 0.
  - starve_cnt=0, cancel=0.
  - Applies mid-transaction. A mem_ready arriving after reset while in IDLE is ignored.
- States: IDLE, INST_BUSY, DATA_BUSY.
- Request eligibility in IDLE:
  - inst_req is eligible only if inst_ready=0 and inst_flush=0 that cycle.
  - data_req is eligible only if data_ready=0.
  - This masks the requester's stale level in its completion cycle.
- Arbitration in IDLE:
  - Data only eligible: grant data.
  - Inst only eligible: grant inst.
  - Both eligible: grant inst if starve_cnt==STARVE_LIMIT, else grant data.
- Grant effects (registered):
  - Next state is DATA_BUSY or INST_BUSY.
  - mem_req=1; mem_addr/we/wdata/wmask are captured from the granted requester.
  - Instruction grants drive mem_we=0 and mem_wmask=0.
  - Latency: request in cycle N gives mem_req in cycle N+1.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each data grant made while inst_req=1.
  - Clears on an inst grant, and when inst_req=0 in IDLE.
- BUSY states:
  - Captured fields stay frozen and upstream inputs are ignored, except inst_flush.
  - On mem_ready, at the next edge: mem_req=0, state=IDLE, the matching rdata is registered from mem_rdata, and the matching ready pulses for 1 cycle.
  - Writes: data_rdata is not updated; only data_ready pulses.
  - Completion latency: mem_ready in cycle M gives the ready pulse in cycle M+1.
  - Arbitration in cycle M+1 follows the IDLE eligibility rules, so the minimum request spacing is 2 idle-to-grant cycles.
- Flush:
  - inst_flush in INST_BUSY sets cancel=1. The downstream read still completes; it is never aborted.
  - On completion with cancel=1 (or inst_flush in the mem_ready cycle): inst_ready stays 0, inst_rdata is not updated, and cancel clears.
  - inst_flush in IDLE or DATA_BUSY has no effect.
- mem_ready in IDLE is ignored.
- inst_ready and data_ready are never both 1 in the same cycle.

Test Plan:
- Reset then single fetch: inst_req=1, inst_addr=0x8000_0000 at cycle 2; memory responds on 1st mem_req cycle with 0x0000_0013. Required: mem_req cycles 3, mem_addr=0x8000_0000, mem_we=0, inst_ready pulse cycle 4, inst_rdata=0x0000_0013.
- Contention: inst_req and data_req (write 0x1000, wdata 0xDEADBEEF, wmask 0xF) asserted together. Required: data granted first with mem_we=1; inst granted after data_ready; fetch completes afterwards.
- Starvation, STARVE_LIMIT=4: data_req held continuously for back-to-back loads while inst_req held. Required: exactly 4 data grants, then 1 inst grant, then data resumes.
- Flush: fetch granted, memory delays mem_ready by 5 cycles, inst_flush pulsed on 2nd busy cycle. Required: no inst_ready for that read; a new inst_req at 0x8000_0040 is granted next.
- Reset mid-op: rst_n low during DATA_BUSY with mem_ready arriving the following cycle. Required: all outputs 0, state IDLE, no data_ready pulse, next request serviced normally.
- Stale-request masking: requester keeps req high for one cycle past its ready pulse. Required: no duplicate mem_req in that cycle.
